// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter serialising byte transfers onto an spi register bus
//
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   reqValid/reqReady          per-requester handshake (reqReady one-hot, IDLE only)
//   reqData, reqCfg            per-requester byte to send and spi configuration word
//   rspValid/rspData/rspError  one-cycle response pulse to the granted requester
//   spiRead/spiWrite           single-cycle register strobes, never both high
//   spiAddress/spiDataOut      register select (0 tx, 1 rx, 2 status, 3 config) and write data
//   spiReadValid/spiDataIn     read return; status bit0 = transmitReady, bit1 = receiveValid
module spi_arbiter #(
    parameter int NUMREQ  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUMREQ-1:0]        reqValid,
    output logic [NUMREQ-1:0]        reqReady,
    input  logic [NUMREQ-1:0][7:0]   reqData,
    input  logic [NUMREQ-1:0][31:0]  reqCfg,
    output logic [NUMREQ-1:0]        rspValid,
    output logic [7:0]               rspData,
    output logic                     rspError,
    output logic                     spiRead,
    output logic                     spiWrite,
    output logic [1:0]               spiAddress,
    output logic [31:0]              spiDataOut,
    input  logic                     spiReadValid,
    input  logic [31:0]              spiDataIn
);

    localparam int IW = (NUMREQ > 1) ? $clog2(NUMREQ) : 1;
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GRANT, CFG, POLLTX, TXWR, POLLRX, RXRD, RESP} state_t;

    state_t          state, state_nx;
    logic [1:0]      rst_sync;
    logic            run;
    logic [IW-1:0]   rr_ptr, grant_idx, winner, winner_nx;
    logic            found;
    logic [7:0]      data_q, rsp_data_q;
    logic [31:0]     cfg_q, cache_cfg;
    logic            cache_valid, pending, rsp_err_q;
    logic [15:0]     wait_cnt;
    logic            read_done, timed_out;
    logic            unused_din;

    assign unused_din = ^spiDataIn[31:8];

    // Reset release is re-timed so the FSM cannot grant before the second edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    // Round-robin search starting at rr_ptr, wrapping modulo NUMREQ.
    always_comb begin
        logic [IW:0] sum;
        found     = 1'b0;
        winner    = '0;
        winner_nx = '0;
        sum       = '0;
        for (int k = 0; k < NUMREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUMREQ)) sum = sum - (IW+1)'(NUMREQ);
            if (!found && reqValid[sum[IW-1:0]]) begin
                found  = 1'b1;
                winner = sum[IW-1:0];
            end
        end
        sum = {1'b0, winner} + (IW+1)'(1);
        if (sum >= (IW+1)'(NUMREQ)) sum = '0;
        winner_nx = sum[IW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        reqReady   = '0;
        rspValid   = '0;
        rspData    = '0;
        rspError   = 1'b0;
        spiRead    = 1'b0;
        spiWrite   = 1'b0;
        spiAddress = 2'd0;
        spiDataOut = '0;
        read_done  = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (run && found) begin
                    reqReady[winner] = 1'b1;
                    state_nx         = GRANT;
                end
            end
            GRANT: state_nx = (!cache_valid || cfg_q != cache_cfg) ? CFG : POLLTX;
            CFG: begin
                spiWrite   = 1'b1;
                spiAddress = 2'd3;
                spiDataOut = cfg_q;
                state_nx   = POLLTX;
            end
            POLLTX, POLLRX, RXRD: begin
                // First cycle strobes; afterwards the bus idles until data or timeout.
                if (!pending) begin
                    spiRead    = 1'b1;
                    spiAddress = (state == RXRD) ? 2'd1 : 2'd2;
                end else if (spiReadValid) begin
                    read_done = 1'b1;
                    case (state)
                        POLLTX:  if (spiDataIn[0]) state_nx = TXWR;
                        POLLRX:  if (spiDataIn[1]) state_nx = RXRD;
                        default: state_nx = RESP;
                    endcase
                end else if (wait_cnt >= WAIT_LIMIT) begin
                    timed_out = 1'b1;
                    state_nx  = RESP;
                end
            end
            TXWR: begin
                spiWrite   = 1'b1;
                spiAddress = 2'd0;
                spiDataOut = {24'b0, data_q};
                state_nx   = POLLRX;
            end
            RESP: begin
                rspValid[grant_idx] = 1'b1;
                rspData             = rsp_data_q;
                rspError            = rsp_err_q;
                state_nx            = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            grant_idx   <= '0;
            data_q      <= '0;
            cfg_q       <= '0;
            cache_cfg   <= '0;
            cache_valid <= 1'b0;
            pending     <= 1'b0;
            wait_cnt    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (state == IDLE && run && found) begin
                grant_idx <= winner;
                data_q    <= reqData[winner];
                cfg_q     <= reqCfg[winner];
                rr_ptr    <= winner_nx;
                pending   <= 1'b0;
            end
            if (state == CFG) begin
                cache_cfg   <= cfg_q;
                cache_valid <= 1'b1;
            end
            if (spiRead || spiWrite) wait_cnt <= '0;
            if (spiRead) pending <= 1'b1;
            if (pending && !spiReadValid && !timed_out) wait_cnt <= wait_cnt + 16'd1;
            if (read_done) begin
                pending <= 1'b0;
                if (state == RXRD) begin
                    rsp_data_q <= spiDataIn[7:0];
                    rsp_err_q  <= 1'b0;
                end
            end
            if (timed_out) begin
                pending     <= 1'b0;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
                cache_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench for spi_arbiter with a loopback spi register model
module tb_spi_arbiter;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      reqValid, reqReady, rspValid;
    logic [N-1:0][7:0] reqData;
    logic [N-1:0][31:0] reqCfg;
    logic [7:0]        rspData;
    logic              rspError, spiRead, spiWrite, spiReadValid;
    logic [1:0]        spiAddress;
    logic [31:0]       spiDataOut, spiDataIn;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_arbiter #(.NUMREQ(N), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqData(reqData), .reqCfg(reqCfg),
        .rspValid(rspValid), .rspData(rspData), .rspError(rspError),
        .spiRead(spiRead), .spiWrite(spiWrite), .spiAddress(spiAddress),
        .spiDataOut(spiDataOut), .spiReadValid(spiReadValid), .spiDataIn(spiDataIn)
    );

    typedef struct { int idx; logic [7:0] data; logic err; } exp_t;
    typedef struct { int idx; logic [7:0] d; logic [31:0] cfg; int cfg_wr; } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          grant_log[$];
    int          accepts = 0, rsps = 0, cfg_writes = 0, tx_writes = 0, bus_viol = 0;
    logic [31:0] last_cfg = '0;
    logic        exp_err_next = 1'b0;
    logic        mute = 1'b0, stray = 1'b0;
    logic        s_rd = 1'b0, s_wr = 1'b0;
    logic [1:0]  s_addr = '0;
    logic [31:0] s_dout = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bus, handshake and response monitor, sampled away from the active edge.
    always @(negedge clk) begin
        s_rd = spiRead; s_wr = spiWrite; s_addr = spiAddress; s_dout = spiDataOut;
        if (reset) begin
            if (spiRead && spiWrite) bus_viol++;
            if (!spiRead && !spiWrite && (spiAddress != 2'd0 || spiDataOut != 32'd0)) bus_viol++;
            if (spiWrite && spiAddress == 2'd3) begin cfg_writes++; last_cfg = spiDataOut; end
            if (spiWrite && spiAddress == 2'd0) tx_writes++;
            for (int i = 0; i < N; i++) begin
                if (reqValid[i] && reqReady[i]) begin
                    accepts++;
                    grant_log.push_back(i);
                    sb.push_back('{idx: i, data: reqData[i], err: exp_err_next});
                end
            end
            if (|rspValid) begin
                rsps++;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(rspValid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_onehot", 64'(rspValid), 64'(1 << mon_e.idx));
                    check("rsp_data", 64'(rspData), mon_e.err ? 64'd0 : 64'(mon_e.data));
                    check("rsp_err", 64'(rspError), 64'(mon_e.err));
                end
            end
        end
    end

    // spi register model: 2-cycle read latency, loopback rx, first tx poll reports not ready.
    initial begin
        int         rd_delay, tx_polls, rx_cd;
        logic [1:0] rd_addr;
        logic       rx_valid;
        logic [7:0] rx_byte;
        rd_delay = 0; tx_polls = 0; rx_cd = 0; rd_addr = '0; rx_valid = 1'b0; rx_byte = '0;
        spiReadValid = 1'b0; spiDataIn = '0;
        forever begin
            @(posedge clk); #1;
            spiReadValid = 1'b0;
            spiDataIn    = '0;
            if (!reset) begin
                rd_delay = 0; tx_polls = 0; rx_cd = 0; rx_valid = 1'b0;
            end else begin
                if (rx_cd > 0) begin rx_cd--; if (rx_cd == 0) rx_valid = 1'b1; end
                if (rd_delay > 0) begin
                    rd_delay--;
                    if (rd_delay == 0) begin
                        spiReadValid = 1'b1;
                        if (rd_addr == 2'd2) begin
                            spiDataIn = {30'b0, rx_valid, 1'(tx_polls > 0)};
                            tx_polls++;
                        end else if (rd_addr == 2'd1) begin
                            spiDataIn = {24'hC0FFEE, rx_byte};
                            rx_valid  = 1'b0;
                            tx_polls  = 0;
                        end
                    end
                end else if (stray) begin
                    spiReadValid = 1'b1;
                    spiDataIn    = 32'hFFFF_FFFF;
                    stray        = 1'b0;
                end
                if (s_rd && !mute) begin rd_delay = 2; rd_addr = s_addr; end
                if (s_wr && s_addr == 2'd0) begin rx_byte = s_dout[7:0]; rx_cd = 3; tx_polls = 0; end
            end
        end
    end

    task automatic run_req(input int idx, input logic [7:0] d, input logic [31:0] c, input logic err);
        int a0, r0, t;
        a0 = accepts; r0 = rsps;
        exp_err_next  = err;
        reqData[idx]  = d;
        reqCfg[idx]   = c;
        reqValid[idx] = 1'b1;
        t = 0;
        while (accepts == a0 && t < 50) begin tick(); t++; end
        reqValid[idx] = 1'b0;
        reqData[idx]  = ~d;
        reqCfg[idx]   = ~c;
        check("accepted", 64'(accepts - a0), 64'd1);
        t = 0;
        while (rsps == r0 && t < 400) begin tick(); t++; end
        check("responded", 64'(rsps - r0), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   c0, t0, a0, r0, t;
        vecs[0] = '{0, 8'hA5, 32'h0005_1000, 1};
        vecs[1] = '{0, 8'h3C, 32'h0005_1000, 0};
        vecs[2] = '{0, 8'h5A, 32'h0005_3400, 1};
        vecs[3] = '{1, 8'h11, 32'h0001_0001, 1};
        vecs[4] = '{2, 8'h22, 32'h0002_0002, 1};
        vecs[5] = '{1, 8'h33, 32'h0001_0001, 1};
        vecs[6] = '{2, 8'h44, 32'h0002_0002, 1};

        reqValid = '1; reqData = '0; reqCfg = '0;
        tick(3);
        check("reset_outputs",
              64'({reqReady, rspValid, rspData, rspError, spiRead, spiWrite, spiAddress, spiDataOut}), 64'd0);
        reqValid = '0;
        reset = 1'b1;
        tick(3);
        stray = 1'b1;
        tick(3);

        for (int v = 0; v < 7; v++) begin
            c0 = cfg_writes; t0 = tx_writes;
            run_req(vecs[v].idx, vecs[v].d, vecs[v].cfg, 1'b0);
            check("cfg_writes", 64'(cfg_writes - c0), 64'(vecs[v].cfg_wr));
            check("tx_writes", 64'(tx_writes - t0), 64'd1);
            if (vecs[v].cfg_wr != 0) check("cfg_value", 64'(last_cfg), 64'(vecs[v].cfg));
        end

        mute = 1'b1;
        run_req(3, 8'h77, 32'h0005_1000, 1'b1);
        mute = 1'b0;
        tick(2);
        c0 = cfg_writes;
        run_req(3, 8'h78, 32'h0005_1000, 1'b0);
        check("cfg_after_timeout", 64'(cfg_writes - c0), 64'd1);

        t0 = tx_writes; a0 = accepts;
        exp_err_next = 1'b0;
        reqData[1] = 8'h99; reqCfg[1] = 32'h0005_1000; reqValid[1] = 1'b1;
        t = 0;
        while (accepts == a0 && t < 50) begin tick(); t++; end
        reqValid[1] = 1'b0;
        t = 0;
        while (tx_writes == t0 && t < 200) begin tick(); t++; end
        tick(1);
        reset = 1'b0;
        #1;
        check("midreset_outputs",
              64'({reqReady, rspValid, rspData, rspError, spiRead, spiWrite, spiAddress, spiDataOut}), 64'd0);
        sb.delete();
        r0 = rsps;
        reqData[2] = 8'h5C; reqCfg[2] = 32'h0005_3400; reqValid[2] = 1'b1;
        tick(4);
        reset = 1'b1;
        @(negedge clk);
        check("release_edge0_ready", 64'(reqReady), 64'd0);
        @(negedge clk);
        check("release_edge1_ready", 64'(reqReady), 64'd0);
        c0 = cfg_writes;
        run_req(2, 8'h5C, 32'h0005_3400, 1'b0);
        check("midreset_no_pulse", 64'(rsps - r0), 64'd1);
        check("cfg_after_reset", 64'(cfg_writes - c0), 64'd1);

        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        grant_log.delete();
        a0 = accepts; r0 = rsps;
        exp_err_next = 1'b0;
        for (int i = 0; i < N; i++) begin
            reqData[i] = 8'hF0 + 8'(i);
            reqCfg[i]  = 32'h0005_1000;
        end
        reqValid = '1;
        t = 0;
        while (accepts - a0 < 8 && t < 1000) begin tick(); t++; end
        reqValid = '0;
        t = 0;
        while (rsps - r0 < 8 && t < 1000) begin tick(); t++; end
        check("fair_rsps", 64'(rsps - r0), 64'd8);
        check("fair_grants", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check("fair_order", 64'(grant_log[i]), 64'(i % 4));

        tick(5);
        check("bus_protocol", 64'(bus_viol), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUMREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles spent waiting on any single spi register read.
REQ-003 clk  input  1: single clock; all logic is rising-edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 reqValid  input  NUMREQ: requester i has a byte transfer pending.
REQ-006 reqReady  output  NUMREQ: one-hot; a request is accepted in the cycle where reqValid[i] and reqReady[i] are both high.
REQ-007 reqData  input  NUMREQ x 8: byte to transmit.
REQ-008 reqCfg  input  NUMREQ x 32: spi configuration word for the requester.
REQ-009 rspValid  output  NUMREQ: one-cycle pulse carrying the received byte.
REQ-010 rspData  output  8: received byte; valid only while a rspValid bit is high.
REQ-011 rspError  output  1: qualifies rspValid; high means the transfer timed out.
REQ-012 spiRead, spiWrite  output  1 each: spi register bus strobes; never both high.
REQ-013 spiAddress  output  2: register select; 0 = tx data, 1 = rx data, 2 = status, 3 = config.
REQ-014 spiDataOut  output  32: write data to the spi block.
REQ-015 spiReadValid  input  1: read data valid.
REQ-016 spiDataIn  input  32: read data; status bit0 = transmitReady, bit1 = receiveValid.

Function
REQ-017 The FSM SHALL have the states IDLE, GRANT, CFG, POLLTX, TXWR, POLLRX, RXRD, RESP.
REQ-018 Arbitration SHALL be round-robin: the search starts at the index after the last grantee, and after reset it starts at index 0.
REQ-019 IDLE -> GRANT: in the cycle a reqValid bit is set, reqReady SHALL pulse for exactly one cycle for the winner, which is selected combinationally from reqValid; the block SHALL latch that requester's reqData, reqCfg and index.
REQ-020 GRANT -> CFG if the latched cfg differs from the cached cfg or the cache is invalid; otherwise GRANT -> POLLTX.
REQ-021 CFG: the block SHALL issue one spiWrite cycle to address 3 with the latched cfg, update the cache, set the cache valid, then go to POLLTX.
REQ-022 POLLTX: the block SHALL issue one spiRead cycle to address 2, then wait for spiReadValid. If bit0 = 1, go to TXWR; otherwise repeat the read.
REQ-023 TXWR: the block SHALL issue one spiWrite cycle to address 0 with {24'b0, data}, then go to POLLRX.
REQ-024 POLLRX: behaves as POLLTX but tests bit1, and exits to RXRD.
REQ-025 RXRD: the block SHALL issue one spiRead cycle to address 1 and wait for spiReadValid.
REQ-026 On that spiReadValid, rspData SHALL equal spiDataIn[7:0]; the block SHALL then go to RESP.
REQ-027 RESP: rspValid[granted index] SHALL be high for one cycle with rspError = 0, then the FSM returns to IDLE.
REQ-028 Exactly one bus strobe cycle SHALL occur per register access; the bus SHALL stay idle (strobes 0, address 0, data 0) while waiting for spiReadValid.
REQ-029 A 16-bit wait counter SHALL clear on each strobe.
REQ-030 If the wait counter reaches TIMEOUT before spiReadValid, the FSM SHALL go to RESP with rspError = 1 and rspData = 0, and SHALL invalidate the cfg cache.
REQ-031 The block SHALL hold only one transfer in flight; reqReady SHALL stay 0 in every state except IDLE.
REQ-032 A spiReadValid arriving when no read is outstanding SHALL be ignored.
REQ-033 A requester dropping reqValid after acceptance SHALL have no effect on the transfer already accepted.

Reset
REQ-034 While reset is low: FSM = IDLE, all outputs 0, cache invalid, round-robin pointer 0, wait counter 0.
REQ-035 When reset is asserted mid-transfer, the transfer SHALL be abandoned with no rspValid pulse.
REQ-036 Reset release SHALL be synchronised so that the FSM leaves IDLE no earlier than the second rising edge of clk after reset rises.

Verification
REQ-037 Single request: requester 0, data 8'hA5, cfg 32'h0005_1000, spi loopback (mosi tied to miso) -> bus sequence cfg write, status polls, tx write, status polls, rx read; rspValid[0] pulses with rspData = 8'hA5 and rspError = 0.
REQ-038 Cfg cache: a second request from requester 0 with the same cfg -> no address-3 write occurs; a new cfg 32'h0005_3400 -> exactly one address-3 write occurs.
REQ-039 Fairness: all 4 requesters held valid for 8 transfers -> grant order 0,1,2,3,0,1,2,3; each rspData matches the byte that requester sent.
REQ-040 Alternating cfgs: requesters 1 and 2 with different cfgs, interleaved -> a cfg write precedes every transfer.
REQ-041 Timeout: spiReadValid forced to 0 with TIMEOUT = 16 -> rspError = 1, rspData = 0, and a cfg write occurs on the next transfer.
REQ-042 Mid-transfer reset: reset asserted during POLLRX -> all outputs 0 immediately, no rspValid pulse; a subsequent transfer completes correctly.
